// File: rtl/stack3.sv
// -----------------------------------------------------------------------------
// stack3 -- register-based hardware stack with a multi-entry shift move.
//
// Entry 0 is top-of-stack. A push shifts every entry down by one and a pop
// shifts up by one (pop-two by two). Vacated bottom entries are refilled with
// FILL. Top-of-stack may be overwritten in the same cycle as any move.
// A saturating valid-entry count and sticky overflow/underflow flags track
// misuse without blocking the data movement.
//
// Parameters
//   WIDTH  data bits per entry (8..64)
//   DEPTH  total entries including top-of-stack (3..64)
//   FILL   value shifted into vacated bottom entries (truncated to WIDTH)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   synchronous active-high reset
//   we       in   write wd into top-of-stack this cycle
//   delta    in   [1:0] pointer move: 00 hold, 01 push, 11 pop, 10 pop-two
//   wd       in   [WIDTH-1:0] write data
//   clr_err  in   clear sticky ovf/unf
//   rd       out  [WIDTH-1:0] entry 0 (registered)
//   rd2      out  [WIDTH-1:0] entry 1 (registered)
//   depth    out  [$clog2(DEPTH+1)-1:0] valid-entry count
//   empty    out  depth == 0
//   full     out  depth == DEPTH
//   ovf      out  sticky overflow (push while full)
//   unf      out  sticky underflow (pop/pop-two past empty)
// -----------------------------------------------------------------------------
module stack3 #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 18,
   parameter logic [63:0] FILL  = 64'h55aa
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [1:0]                   delta,
   input  logic [WIDTH-1:0]             wd,
   input  logic                         clr_err,
   output logic [WIDTH-1:0]             rd,
   output logic [WIDTH-1:0]             rd2,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         ovf,
   output logic                         unf
);

   localparam int unsigned   DW     = $clog2(DEPTH + 1);
   localparam logic [WIDTH-1:0] FILL_W = FILL[WIDTH-1:0];
   localparam logic [DW-1:0] DEPTH_C = DW'(DEPTH);

   typedef enum logic [1:0] {
      MOVE_HOLD = 2'b00,
      MOVE_PUSH = 2'b01,
      MOVE_POP2 = 2'b10,
      MOVE_POP  = 2'b11
   } move_e;

   logic [WIDTH-1:0] e_q [DEPTH];
   logic [WIDTH-1:0] e_d [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             ovf_set, unf_set;
   move_e            move;

   assign move = move_e'(delta);

   // Data path: shift the whole array according to the move, then let a write
   // replace whatever landed in entry 0.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned -- otherwise synthesis infers a latch.
      e_d = e_q;
      unique case (move)
         MOVE_HOLD: ;
         MOVE_PUSH: begin
            // entry 0 keeps its value (dup) unless overwritten below
            for (int i = 1; i < DEPTH; i++) e_d[i] = e_q[i-1];
         end
         MOVE_POP: begin
            for (int i = 0; i < DEPTH - 1; i++) e_d[i] = e_q[i+1];
            e_d[DEPTH-1] = FILL_W;
         end
         MOVE_POP2: begin
            for (int i = 0; i < DEPTH - 2; i++) e_d[i] = e_q[i+2];
            e_d[DEPTH-2] = FILL_W;
            e_d[DEPTH-1] = FILL_W;
         end
         default: ;
      endcase
      if (we) e_d[0] = wd;
   end

   // Count path: saturate at 0 and DEPTH, raising the matching error instead.
   always_comb begin
      depth_d = depth_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (move)
         MOVE_HOLD: ;
         MOVE_PUSH: begin
            if (depth_q == DEPTH_C) ovf_set = 1'b1;
            else                    depth_d = depth_q + DW'(1);
         end
         MOVE_POP: begin
            if (depth_q == '0) unf_set = 1'b1;
            else               depth_d = depth_q - DW'(1);
         end
         MOVE_POP2: begin
            if (depth_q >= DW'(2)) begin
               depth_d = depth_q - DW'(2);
            end else begin
               depth_d = '0;
               unf_set = 1'b1;
            end
         end
         default: ;
      endcase
      // A new error wins over a simultaneous clear.
      ovf_d = (ovf_q & ~clr_err) | ovf_set;
      unf_d = (unf_q & ~clr_err) | unf_set;
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (rst) begin
         // NOTE: the entry array is reset too -- FILL contents are visible on
         // rd/rd2 and shift up on pops, so they are architectural state.
         for (int i = 0; i < DEPTH; i++) e_q[i] <= FILL_W;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         e_q     <= e_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign rd    = e_q[0];
   assign rd2   = e_q[1];
   assign depth = depth_q;
   assign empty = (depth_q == '0);
   assign full  = (depth_q == DEPTH_C);
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: doc/stack3.md
STACK3 -- requirements
Module: stack3

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per entry (legal 8..64).
REQ-002 SHALL have parameter DEPTH, default 18, total entries including top-of-stack (legal 3..64).
REQ-003 SHALL have parameter FILL, default 16'h55aa zero-extended/truncated to WIDTH, value shifted into vacated bottom entries.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port we, input, 1, write wd into top-of-stack this cycle.
REQ-007 SHALL have port delta, input, 2, signed stack-pointer move: 00 hold, 01 push, 11 pop, 10 pop-two.
REQ-008 SHALL have port wd, input, WIDTH, write data.
REQ-009 SHALL have port clr_err, input, 1, clear sticky error flags.
REQ-010 SHALL have port rd, output, WIDTH, top-of-stack (entry 0).
REQ-011 SHALL have port rd2, output, WIDTH, next-of-stack (entry 1).
REQ-012 SHALL have port depth, output, $clog2(DEPTH+1), count of valid entries.
REQ-013 SHALL have ports empty and full, output, 1 each, depth==0 and depth==DEPTH.
REQ-014 SHALL have ports ovf and unf, output, 1 each, sticky overflow/underflow flags.

Function
REQ-015 SHALL hold entries e[0..DEPTH-1] in registers; rd=e[0], rd2=e[1], both driven directly from registers (no combinational path from inputs).
REQ-016 delta=00: e[i] unchanged for i>=1; e[0]<=wd if we, else unchanged; depth unchanged.
REQ-017 delta=01 (push): e[i+1]<=e[i] for all i; e[DEPTH-1] old value discarded; e[0]<=wd if we, else e[0] retained (dup).
REQ-018 delta=11 (pop): e[i]<=e[i+1]; e[DEPTH-1]<=FILL; if we, e[0]<=wd instead of e[1].
REQ-019 delta=10 (pop-two): e[i]<=e[i+2]; e[DEPTH-2], e[DEPTH-1]<=FILL; if we, e[0]<=wd instead of e[2].
REQ-020 All data and count updates SHALL take effect in one cycle; new rd/rd2/depth visible the cycle after the edge.
REQ-021 depth SHALL increment by 1 on push, decrement by 1 on pop, decrement by 2 on pop-two, saturating at DEPTH and 0.
REQ-022 Push with depth==DEPTH: data shifts per REQ-017, depth stays DEPTH, ovf set.
REQ-023 Pop with depth==0: data shifts per REQ-018, depth stays 0, unf set.
REQ-024 Pop-two with depth==1: depth->0, unf set; with depth==0: depth stays 0, unf set.
REQ-025 we with delta=00 or any delta SHALL NOT itself change depth or flags.
REQ-026 ovf/unf SHALL remain set until clr_err; clr_err and a new error in the same cycle SHALL leave the flag set.
REQ-027 clr_err SHALL NOT affect data or depth.
REQ-028 empty/full SHALL be decoded from the registered depth (same cycle as depth).

Reset
REQ-029 rst high at an edge SHALL set all e[i]=FILL, depth=0, ovf=0, unf=0, overriding we/delta/clr_err that cycle.
REQ-030 After reset: rd=FILL, rd2=FILL, empty=1, full=0.
REQ-031 Reset asserted mid-sequence SHALL discard pending stack contents; first op after rst low behaves as on empty stack.

Verification
REQ-032 Reset, then push wd=1,2,3 with we=1 -> rd=3, rd2=2, depth=3, empty=0, no flags.
REQ-033 From 1,2,3: pop-two no we -> rd=1, rd2=FILL(16'h55aa), depth=1; then pop-two -> depth=0, unf=1.
REQ-034 DEPTH=18: push 19 values 1..19 -> depth=18, full=1, ovf=1, rd=19; pop 17 times -> rd=2 (value 1 lost? no: value 1 discarded, rd=2 after 17 pops), depth=1.
REQ-035 Stack 5,6: delta=11 with we=1, wd=9 -> rd=9, depth=1 (replace-on-pop); delta=00 we=1 wd=4 -> rd=4, depth=1.
REQ-036 unf=1, assert clr_err with pop on empty same cycle -> unf stays 1; clr_err alone next cycle -> unf=0, depth=0.
REQ-037 Push 4 values, assert rst with delta=01 we=1 -> next cycle rd=FILL, depth=0, flags 0.
